// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state codes, AXI constants and sizing helpers
// for the single-outstanding AXI3 read-channel arbiter.
package axi_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ADDR = 2'd1;
  localparam state_t DATA = 2'd2;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first requester at or
// after the pointer, wrapping modulo N.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          any_o
);

  int idx;

  // Walk farthest-first so the nearest requester is written last and wins.
  always_comb begin
    gnt_o = '0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) gnt_o = IW'(idx);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: N-master to 1-slave AXI3 read arbiter, one burst
// in flight, round-robin on AR, flags rlast/arlen disagreement.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 4,
  parameter int ID_W    = 32,
  parameter int DATA_W  = 128
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [NUM_MST-1:0]        m_arvalid,
  input  logic [NUM_MST*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MST*LEN_W-1:0]  m_arlen,
  input  logic [NUM_MST*3-1:0]      m_arsize,
  input  logic [NUM_MST*2-1:0]      m_arburst,
  input  logic [NUM_MST*ID_W-1:0]   m_arid,
  output logic [NUM_MST-1:0]        m_arready,
  output logic [NUM_MST-1:0]        m_rvalid,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [1:0]                m_rresp,
  output logic [ID_W-1:0]           m_rid,
  output logic                      m_rlast,
  input  logic [NUM_MST-1:0]        m_rready,
  output logic                      s_arvalid,
  output logic [ADDR_W-1:0]         s_araddr,
  output logic [LEN_W-1:0]          s_arlen,
  output logic [2:0]                s_arsize,
  output logic [1:0]                s_arburst,
  output logic [ID_W-1:0]           s_arid,
  input  logic                      s_arready,
  input  logic                      s_rvalid,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic [1:0]                s_rresp,
  input  logic [ID_W-1:0]           s_rid,
  input  logic                      s_rlast,
  output logic                      s_rready,
  output logic                      busy,
  output logic [$clog2(NUM_MST)-1:0] grant,
  output logic                      len_err
);

  localparam int GW = idx_w(NUM_MST);

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   pick, next_ptr;
  logic [LEN_W:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] exp_len_q, exp_len_d;
  logic            len_err_q, len_err_d;
  logic            any_req, ar_hs, r_hs, last_hit;

  logic [ADDR_W-1:0] addr_a  [NUM_MST];
  logic [LEN_W-1:0]  len_a   [NUM_MST];
  logic [2:0]        size_a  [NUM_MST];
  logic [1:0]        burst_a [NUM_MST];
  logic [ID_W-1:0]   id_a    [NUM_MST];

  for (genvar i = 0; i < NUM_MST; i++) begin : g_slice
    assign addr_a[i]  = m_araddr[i*ADDR_W +: ADDR_W];
    assign len_a[i]   = m_arlen[i*LEN_W +: LEN_W];
    assign size_a[i]  = m_arsize[i*3 +: 3];
    assign burst_a[i] = m_arburst[i*2 +: 2];
    assign id_a[i]    = m_arid[i*ID_W +: ID_W];
  end

  rr_arbiter #(
    .N  (NUM_MST),
    .IW (GW)
  ) u_rr (
    .req_i (m_arvalid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick),
    .any_o (any_req)
  );

  assign s_arvalid = (state_q == ADDR);
  assign s_araddr  = addr_a[grant_q];
  assign s_arlen   = len_a[grant_q];
  assign s_arsize  = size_a[grant_q];
  assign s_arburst = burst_a[grant_q];
  assign s_arid    = id_a[grant_q];
  assign s_rready  = (state_q == DATA) && m_rready[grant_q];

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rid   = s_rid;
  assign m_rlast = s_rlast;

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    if (state_q == ADDR) m_arready[grant_q] = s_arready;
    if (state_q == DATA) m_rvalid[grant_q] = s_rvalid;
  end

  assign ar_hs    = s_arvalid && s_arready;
  assign r_hs     = s_rvalid && s_rready;
  assign last_hit = (beat_cnt_q == {1'b0, exp_len_q});
  assign next_ptr = (grant_q == GW'(NUM_MST - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    exp_len_d  = exp_len_q;
    len_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          exp_len_d = len_a[grant_q];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + (LEN_W+1)'(1);
          // A mismatch is flagged but rlast alone ends the burst.
          if (s_rlast) begin
            len_err_d = !last_hit;
            state_d   = IDLE;
            rr_ptr_d  = next_ptr;
          end else begin
            len_err_d = last_hit;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      exp_len_q  <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      exp_len_q  <= exp_len_d;
      len_err_q  <= len_err_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: random masters and slave against a transaction-level
// arbiter model; a negedge monitor scores DUT outputs.
module tb_axi_rd_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int LW = 4;
  localparam int IW = 32;
  localparam int DW = 128;
  localparam int GW = $clog2(NM);

  typedef struct {
    int            m;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [IW-1:0] id;
  } ar_t;

  typedef struct {
    int            m;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              aresetn;
  logic [NM-1:0]     m_arvalid;
  logic [NM*AW-1:0]  m_araddr;
  logic [NM*LW-1:0]  m_arlen;
  logic [NM*3-1:0]   m_arsize;
  logic [NM*2-1:0]   m_arburst;
  logic [NM*IW-1:0]  m_arid;
  logic [NM-1:0]     m_arready;
  logic [NM-1:0]     m_rvalid;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic [IW-1:0]     m_rid;
  logic              m_rlast;
  logic [NM-1:0]     m_rready;
  logic              s_arvalid;
  logic [AW-1:0]     s_araddr;
  logic [LW-1:0]     s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic [IW-1:0]     s_arid;
  logic              s_arready;
  logic              s_rvalid;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic [IW-1:0]     s_rid;
  logic              s_rlast;
  logic              s_rready;
  logic              busy;
  logic [GW-1:0]     grant;
  logic              len_err;

  axi_rd_arbiter #(
    .NUM_MST (NM), .ADDR_W (AW), .LEN_W (LW), .ID_W (IW), .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .m_arvalid (m_arvalid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arid    (m_arid),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rid     (m_rid),
    .m_rlast   (m_rlast),
    .m_rready  (m_rready),
    .s_arvalid (s_arvalid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_arid    (s_arid),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rid     (s_rid),
    .s_rlast   (s_rlast),
    .s_rready  (s_rready),
    .busy      (busy),
    .grant     (grant),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;

  ar_t   mq [NM][$];
  ar_t   exp_ar_q [$];
  beat_t exp_b_q [$];
  beat_t sl_q [$];

  // Model: ph 0 = free, 1 = address phase, 2 = data phase.
  int    ph = 0;
  int    ptr = 0;
  int    mg = 0;
  int    beat_k = 0;
  int    nburst = 0;
  ar_t   cur;
  bit    exp_le = 1'b0;
  bit    rst_flag = 1'b0;
  bit    mon_en = 1'b0;
  bit    sl_pres = 1'b0;
  bit    eager = 1'b0;
  bit    no_err = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NM-1:0] r, input int p);
    for (int k = 0; k < NM; k++)
      if (r[(p + k) % NM]) return (p + k) % NM;
    return 0;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NM; i++)
      if (mq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic plan_burst();
    int    nb;
    beat_t b;
    nb = int'(cur.len) + 1;
    if (!no_err && $urandom_range(0, 4) == 0) begin
      do nb = $urandom_range(1, int'(cur.len) + 3);
      while (nb == int'(cur.len) + 1);
    end
    nburst++;
    for (int k = 0; k < nb; k++) begin
      b.m    = mg;
      b.data = {32'(nburst), cur.addr, 32'(k), cur.id};
      b.resp = 2'($urandom_range(0, 3));
      b.id   = cur.id;
      b.last = (k == nb - 1);
      sl_q.push_back(b);
      exp_b_q.push_back(b);
    end
    beat_k = 0;
  endtask

  task automatic step();
    logic [NM-1:0] req_c, arhs_c;
    logic          sar_c, rhs_c, rst_c;
    beat_t         b;
    @(negedge clk);
    req_c  = m_arvalid;
    arhs_c = m_arvalid & m_arready;
    sar_c  = s_arvalid & s_arready;
    rhs_c  = s_rvalid & s_rready;
    rst_c  = aresetn;
    @(posedge clk);
    #1;
    exp_le = 1'b0;
    if (!rst_c) begin
      ph = 0; ptr = 0; mon_en = 1'b1; rst_flag = 1'b1;
      exp_ar_q.delete(); exp_b_q.delete(); sl_q.delete();
      sl_pres = 1'b0; s_rvalid = 1'b0; m_arvalid = '0;
    end else begin
      rst_flag = 1'b0;
      if (ph == 0 && |req_c) begin
        mg = rr_pick(req_c, ptr);
        cur = mq[mg][0];
        cur.m = mg;
        exp_ar_q.push_back(cur);
        ph = 1;
      end else if (ph == 1 && sar_c) begin
        plan_burst();
        ph = 2;
      end else if (ph == 2 && rhs_c && sl_pres) begin
        b = sl_q.pop_front();
        sl_pres = 1'b0;
        exp_le = b.last ? (beat_k != int'(cur.len)) : (beat_k == int'(cur.len));
        beat_k++;
        if (b.last) begin
          ph = 0;
          ptr = (mg + 1) % NM;
        end
      end
      for (int i = 0; i < NM; i++)
        if (arhs_c[i] && mq[i].size() > 0) begin
          void'(mq[i].pop_front());
          m_arvalid[i] = 1'b0;
        end
      for (int i = 0; i < NM; i++)
        if (!m_arvalid[i] && mq[i].size() > 0 &&
            (eager || $urandom_range(0, 2) != 0)) begin
          m_arvalid[i]            = 1'b1;
          m_araddr[i*AW +: AW]    = mq[i][0].addr;
          m_arlen[i*LW +: LW]     = mq[i][0].len;
          m_arsize[i*3 +: 3]      = mq[i][0].size;
          m_arburst[i*2 +: 2]     = mq[i][0].burst;
          m_arid[i*IW +: IW]      = mq[i][0].id;
        end
      // With nothing to send, rvalid carries noise that must be ignored.
      if (sl_q.size() == 0) begin
        sl_pres  = 1'b0;
        s_rvalid = 1'($urandom_range(0, 1));
        s_rdata  = {4{$urandom}};
        s_rlast  = 1'($urandom_range(0, 1));
        s_rid    = $urandom;
        s_rresp  = 2'($urandom_range(0, 3));
      end else if (!sl_pres && $urandom_range(0, 3) != 0) begin
        sl_pres  = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = sl_q[0].data;
        s_rlast  = sl_q[0].last;
        s_rid    = sl_q[0].id;
        s_rresp  = sl_q[0].resp;
      end else if (!sl_pres) begin
        s_rvalid = 1'b0;
      end
    end
    s_arready = 1'($urandom_range(0, 1));
    m_rready  = NM'($urandom);
  endtask

  task automatic run_until_idle(input string nm, input int bound);
    int n = 0;
    while ((ph != 0 || pending()) && n < bound) begin
      step();
      n++;
    end
    chk(nm, (n >= bound), 0);
  endtask

  bit    ar_seen = 1'b0;
  ar_t   ea;
  beat_t eb;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("len_err", len_err, exp_le);
      chk("busy", busy, (ph != 0));
      if (rst_flag) chk("grant_rst", grant, 0);
      if (ph == 0) begin
        ar_seen = 1'b0;
        chk("idle_arvalid", s_arvalid, 0);
        chk("idle_arready", m_arready, 0);
        chk("idle_rvalid", m_rvalid, 0);
        chk("idle_rready", s_rready, 0);
      end else if (ph == 1) begin
        chk("s_arvalid", s_arvalid, 1);
        if (!ar_seen) begin
          ar_seen = 1'b1;
          chk("ar_expected", exp_ar_q.size() > 0, 1);
          if (exp_ar_q.size() > 0) begin
            ea = exp_ar_q.pop_front();
            chk("grant", grant, ea.m);
            chk("ar_fields", {s_araddr, s_arlen, s_arsize, s_arburst, s_arid},
                {ea.addr, ea.len, ea.size, ea.burst, ea.id});
          end
        end
        chk("m_arready", m_arready, s_arready ? (1 << mg) : 0);
        chk("addr_rready", s_rready, 0);
        chk("addr_rvalid", m_rvalid, 0);
      end else begin
        ar_seen = 1'b0;
        chk("data_arvalid", s_arvalid, 0);
        chk("data_arready", m_arready, 0);
        chk("m_rvalid", m_rvalid, s_rvalid ? (1 << mg) : 0);
        chk("s_rready", s_rready, m_rready[mg]);
        if (|(m_rvalid & m_rready)) begin
          chk("r_expected", exp_b_q.size() > 0, 1);
          if (exp_b_q.size() > 0) begin
            eb = exp_b_q.pop_front();
            chk("r_master", m_rvalid, 1 << eb.m);
            chk("rdata", m_rdata, eb.data);
            chk("rid", m_rid, eb.id);
            chk("rresp", m_rresp, eb.resp);
            chk("rlast", m_rlast, eb.last);
          end
        end
      end
    end
  end

  initial begin
    ar_t r;
    int  n;
    aresetn = 1'b0;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_arburst = '0; m_arid = '0; m_rready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    s_rid = '0; s_rlast = 1'b0;
    repeat (3) step();
    aresetn = 1'b1;

    for (int i = 0; i < NM; i++)
      for (int j = 0; j < 30; j++) begin
        r.m     = i;
        r.addr  = $urandom;
        r.len   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3))
                                             : 4'($urandom_range(0, 15));
        r.size  = 3'($urandom_range(0, 4));
        r.burst = 2'($urandom_range(0, 2));
        r.id    = $urandom;
        mq[i].push_back(r);
      end
    run_until_idle("random_drain_timeout", 20000);

    eager = 1'b1;
    no_err = 1'b1;
    mq[0].push_back('{m:0, addr:32'h1000, len:4'd3, size:3'd4,
                      burst:2'b01, id:32'h10});
    run_until_idle("single_burst_timeout", 300);

    mq[0].push_back('{m:0, addr:32'h2000, len:4'd3, size:3'd4,
                      burst:2'b01, id:32'h20});
    n = 0;
    while (!(ph == 2 && beat_k >= 1) && n < 300) begin
      step();
      n++;
    end
    chk("midburst_timeout", (n >= 300), 0);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    mq[0].push_back('{m:0, addr:32'h3000, len:4'd1, size:3'd4,
                      burst:2'b01, id:32'h30});
    mq[1].push_back('{m:1, addr:32'h4000, len:4'd2, size:3'd4,
                      burst:2'b01, id:32'h41});
    run_until_idle("post_reset_timeout", 300);
    step();

    chk("beats_drained", exp_b_q.size(), 0);
    chk("ar_drained", exp_ar_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
